// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the hazard scoreboard: stage numbering,
// result-availability encodings and the stall counter ceiling.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        STG_ID  = 2'd0,
        STG_EX  = 2'd1,
        STG_MEM = 2'd2,
        STG_WB  = 2'd3
    } stage_e;

    // Stage at whose end a writer's result exists.
    localparam logic [1:0] AVAIL_ALU  = 2'd1;
    localparam logic [1:0] AVAIL_LOAD = 2'd2;

    // Stage at which a source operand is consumed.
    localparam logic [1:0] NEED_ID = 2'd0;
    localparam logic [1:0] NEED_EX = 2'd1;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request bundle and the hazard/forwarding results returned to it.
interface hazard_scoreboard_if #(
    parameter int NSRC = 2,
    parameter int AW   = 5,
    parameter int SW   = 2
);
    logic                 id_valid;
    logic                 id_flush;
    logic                 id_wr;
    logic [AW-1:0]        id_dst;
    logic [SW-1:0]        id_avail;
    logic [NSRC*AW-1:0]   id_src;
    logic [NSRC-1:0]      id_src_used;
    logic [NSRC*SW-1:0]   id_src_need;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_id;
    logic [NSRC*SW-1:0]   fwd_ex;
    logic [15:0]          stall_cnt;

    modport master (
        output id_valid, id_flush, id_wr, id_dst, id_avail,
               id_src, id_src_used, id_src_need,
        input  stall, fwd_id, fwd_ex, stall_cnt
    );

    modport slave (
        input  id_valid, id_flush, id_wr, id_dst, id_avail,
               id_src, id_src_used, id_src_need,
        output stall, fwd_id, fwd_ex, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard_match.sv
// Priority search of one source register over all scoreboard slots.
// Slot index k+1 corresponds to flat position k; slot 1 is the youngest.
module hazard_match #(
    parameter int AW    = 5,
    parameter int SW    = 2,
    parameter int DEPTH = 3
) (
    input  logic [AW-1:0]       i_src,
    input  logic                i_used,
    input  logic [DEPTH-1:0]    i_slot_valid,
    input  logic [DEPTH*AW-1:0] i_slot_dst,
    input  logic [DEPTH*SW-1:0] i_slot_avail,
    output logic                o_hit,
    output logic [SW-1:0]       o_slot,
    output logic [SW-1:0]       o_avail
);

    // Scan oldest to youngest so the youngest matching writer is the last one assigned.
    always_comb begin
        o_hit   = 1'b0;
        o_slot  = '0;
        o_avail = '0;
        if (i_used && (i_src != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (i_slot_valid[k] && (i_slot_dst[k*AW +: AW] == i_src)) begin
                    o_hit   = 1'b1;
                    o_slot  = SW'(k + 1);
                    o_avail = i_slot_avail[k*SW +: SW];
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding-select unit. In-flight writers are kept in
// a shift register with one slot per post-ID stage; each ID source is matched
// against it to produce the stall request and forwarding selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NSRC  = 2,
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int SW    = 2
) (
    input logic              clk,
    input logic              rst,
    hazard_scoreboard_if.slave bus
);

    logic [DEPTH-1:0]    r_slot_valid;
    logic [DEPTH*AW-1:0] r_slot_dst;
    logic [DEPTH*SW-1:0] r_slot_avail;
    logic [NSRC*SW-1:0]  r_fwd_ex;
    logic [15:0]         r_stall_cnt;

    logic [NSRC-1:0]     w_hit;
    logic [NSRC*SW-1:0]  w_slot;
    logic [NSRC*SW-1:0]  w_avail;
    logic [NSRC-1:0]     w_src_stall;
    logic [NSRC*SW-1:0]  w_fwd_id;
    logic [NSRC*SW-1:0]  w_fwd_ex_next;
    logic                w_stall;
    logic                w_issue;
    logic                w_enter;

    for (genvar j = 0; j < NSRC; j++) begin : g_src
        hazard_match #(
            .AW    (AW),
            .SW    (SW),
            .DEPTH (DEPTH)
        ) u_match (
            .i_src        (bus.id_src[j*AW +: AW]),
            .i_used       (bus.id_src_used[j]),
            .i_slot_valid (r_slot_valid),
            .i_slot_dst   (r_slot_dst),
            .i_slot_avail (r_slot_avail),
            .o_hit        (w_hit[j]),
            .o_slot       (w_slot[j*SW +: SW]),
            .o_avail      (w_avail[j*SW +: SW])
        );
    end

    // Per source: stall while the value is not ready by the consuming stage, and
    // pick the slot to forward from now (ID) and one stage later (EX).
    always_comb begin
        logic [SW:0] v_slot;
        logic [SW:0] v_avail;
        logic [SW:0] v_need;
        logic [SW:0] v_next;
        w_src_stall   = '0;
        w_fwd_id      = '0;
        w_fwd_ex_next = '0;
        v_slot        = '0;
        v_avail       = '0;
        v_need        = '0;
        v_next        = '0;
        for (int j = 0; j < NSRC; j++) begin
            v_slot  = {1'b0, w_slot[j*SW +: SW]};
            v_avail = {1'b0, w_avail[j*SW +: SW]};
            v_need  = {1'b0, bus.id_src_need[j*SW +: SW]};
            v_next  = v_slot + 1'b1;
            if (w_hit[j]) begin
                if ((v_slot + v_need) <= v_avail) begin
                    w_src_stall[j] = 1'b1;
                end
                if (v_slot > v_avail) begin
                    w_fwd_id[j*SW +: SW] = w_slot[j*SW +: SW];
                end
                // Past the last slot the writer has retired and the regfile holds the value.
                if ((v_next <= (SW+1)'(DEPTH)) && (v_next > v_avail)) begin
                    w_fwd_ex_next[j*SW +: SW] = v_next[SW-1:0];
                end
            end
        end
    end

    assign w_stall = |w_src_stall;
    assign w_issue = bus.id_valid & ~bus.id_flush & ~w_stall;
    assign w_enter = w_issue & bus.id_wr & (bus.id_dst != '0);

    // Advance the scoreboard one stage, entering the issuing writer into slot 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_valid <= '0;
            r_slot_dst   <= '0;
            r_slot_avail <= '0;
        end else begin
            r_slot_valid[0]     <= w_enter;
            r_slot_dst[0 +: AW] <= bus.id_dst;
            r_slot_avail[0 +: SW] <= bus.id_avail;
            for (int k = 1; k < DEPTH; k++) begin
                r_slot_valid[k]         <= r_slot_valid[k-1];
                r_slot_dst[k*AW +: AW]  <= r_slot_dst[(k-1)*AW +: AW];
                r_slot_avail[k*SW +: SW] <= r_slot_avail[(k-1)*SW +: SW];
            end
        end
    end

    // Latch the EX operand select for the issuing instruction; bubbles select the ID value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fwd_ex <= '0;
        end else if (w_issue) begin
            r_fwd_ex <= w_fwd_ex_next;
        end else begin
            r_fwd_ex <= '0;
        end
    end

    // Count stall cycles, holding at the ceiling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.fwd_id    = w_fwd_id;
    assign bus.fwd_ex    = r_fwd_ex;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a cycle-by-cycle vector table with
// hand-computed outputs, an asynchronous reset during a stall, and counter
// saturation on a deeper second instance.
module tb_hazard_scoreboard;

    typedef struct {
        logic        v;
        logic        fl;
        logic        wr;
        logic [4:0]  dst;
        logic [1:0]  av;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [1:0]  used;
        logic [1:0]  n0;
        logic [1:0]  n1;
        logic        expStall;
        logic [1:0]  expFi0;
        logic [1:0]  expFi1;
        logic [1:0]  expFe0;
        logic [1:0]  expFe1;
        logic [15:0] expCnt;
    } vec_t;

    logic clk;
    logic rst;
    int   tests;
    int   failures;

    vec_t tbl[32];

    hazard_scoreboard_if #(.NSRC(2), .AW(5), .SW(2)) bus ();
    hazard_scoreboard_if #(.NSRC(2), .AW(5), .SW(4)) bus2 ();

    hazard_scoreboard #(.NSRC(2), .AW(5), .DEPTH(3), .SW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hazard_scoreboard #(.NSRC(2), .AW(5), .DEPTH(15), .SW(4)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Free-running pipeline clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(int v, int fl, int wr, int dst, int av,
                                   int s0, int s1, int used, int n0, int n1,
                                   int st, int fi0, int fi1, int fe0, int fe1, int cnt);
        vec_t r;
        r.v = 1'(v);  r.fl = 1'(fl);  r.wr = 1'(wr);
        r.dst = 5'(dst);  r.av = 2'(av);
        r.s0 = 5'(s0);  r.s1 = 5'(s1);  r.used = 2'(used);
        r.n0 = 2'(n0);  r.n1 = 2'(n1);
        r.expStall = 1'(st);
        r.expFi0 = 2'(fi0);  r.expFi1 = 2'(fi1);
        r.expFe0 = 2'(fe0);  r.expFe1 = 2'(fe1);
        r.expCnt = 16'(cnt);
        return r;
    endfunction

    function automatic vec_t bubble(int fe0, int cnt);
        return mkVec(0,0,0,0,0, 0,0,0,0,0, 0,0,0,fe0,0,cnt);
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.id_valid    = v.v;
        bus.id_flush    = v.fl;
        bus.id_wr       = v.wr;
        bus.id_dst      = v.dst;
        bus.id_avail    = v.av;
        bus.id_src      = {v.s1, v.s0};
        bus.id_src_used = v.used;
        bus.id_src_need = {v.n1, v.n0};
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic runRow(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #2;
        checkOutput({tag, " stall"},     16'(bus.stall),        16'(v.expStall));
        checkOutput({tag, " fwd_id0"},   16'(bus.fwd_id[1:0]),  16'(v.expFi0));
        checkOutput({tag, " fwd_id1"},   16'(bus.fwd_id[3:2]),  16'(v.expFi1));
        checkOutput({tag, " fwd_ex0"},   16'(bus.fwd_ex[1:0]),  16'(v.expFe0));
        checkOutput({tag, " fwd_ex1"},   16'(bus.fwd_ex[3:2]),  16'(v.expFe1));
        checkOutput({tag, " stall_cnt"}, bus.stall_cnt,         v.expCnt);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " stall"},     16'(bus.stall),  16'd0);
        checkOutput({tag, " fwd_id"},    16'(bus.fwd_id), 16'd0);
        checkOutput({tag, " fwd_ex"},    16'(bus.fwd_ex), 16'd0);
        checkOutput({tag, " stall_cnt"}, bus.stall_cnt,   16'd0);
    endtask

    // Directed test sequence.
    initial begin
        vec_t lw5;
        vec_t use5;
        tests    = 0;
        failures = 0;

        // Back-to-back ALU: r4 <- r3 forwards from MEM next cycle.
        tbl[0]  = mkVec(1,0,1,3,1,  1,2,3,1,1,  0,0,0,0,0,0);
        tbl[1]  = mkVec(1,0,1,4,1,  3,1,3,1,1,  0,0,0,0,0,0);
        tbl[2]  = bubble(2,0);
        tbl[3]  = bubble(0,0);
        tbl[4]  = bubble(0,0);
        // Load-use: one stall, then forward from WB.
        tbl[5]  = mkVec(1,0,1,5,2,  1,0,1,1,1,  0,0,0,0,0,0);
        tbl[6]  = mkVec(1,0,1,6,1,  5,2,3,1,1,  1,0,0,0,0,0);
        tbl[7]  = mkVec(1,0,1,6,1,  5,2,3,1,1,  0,0,0,0,0,1);
        tbl[8]  = bubble(3,1);
        tbl[9]  = bubble(0,1);
        tbl[10] = bubble(0,1);
        // Branch after ALU: one stall, then ID forward from MEM.
        tbl[11] = mkVec(1,0,1,2,1,  1,1,3,1,1,  0,0,0,0,0,1);
        tbl[12] = mkVec(1,0,0,0,1,  2,7,3,0,0,  1,0,0,0,0,1);
        tbl[13] = mkVec(1,0,0,0,1,  2,7,3,0,0,  0,2,0,0,0,2);
        tbl[14] = bubble(3,2);
        // Load feeding an ID consumer: two stalls, WB forward, retired at EX.
        tbl[15] = mkVec(1,0,1,9,2,  1,0,1,1,1,  0,0,0,0,0,2);
        tbl[16] = mkVec(1,0,0,0,1,  9,0,1,0,0,  1,0,0,0,0,2);
        tbl[17] = mkVec(1,0,0,0,1,  9,0,1,0,0,  1,0,0,0,0,3);
        tbl[18] = mkVec(1,0,0,0,1,  9,0,1,0,0,  0,3,0,0,0,4);
        tbl[19] = bubble(0,4);
        // Shadowing: younger load of r8 wins over the older ALU write.
        tbl[20] = mkVec(1,0,1,8,1,  1,0,1,1,1,  0,0,0,0,0,4);
        tbl[21] = mkVec(1,0,1,8,2,  2,0,1,1,1,  0,0,0,0,0,4);
        tbl[22] = mkVec(1,0,1,10,1, 8,0,1,1,1,  1,0,0,0,0,4);
        tbl[23] = mkVec(1,0,1,10,1, 8,0,1,1,1,  0,0,0,0,0,5);
        tbl[24] = bubble(3,5);
        tbl[25] = bubble(0,5);
        tbl[26] = bubble(0,5);
        // Register 0 never tracked; flushed writer never entered, flush beats stall.
        tbl[27] = mkVec(1,0,1,0,1,  1,0,1,1,1,  0,0,0,0,0,5);
        tbl[28] = mkVec(1,0,1,11,1, 0,0,3,0,0,  0,0,0,0,0,5);
        tbl[29] = mkVec(1,1,1,12,1, 11,0,1,0,0, 1,0,0,0,0,5);
        tbl[30] = mkVec(1,0,0,0,1,  12,0,1,1,1, 0,0,0,0,0,6);
        tbl[31] = bubble(0,6);

        applyStimulus(bubble(0,0));
        bus2.id_valid    = 1'b0;
        bus2.id_flush    = 1'b0;
        bus2.id_wr       = 1'b0;
        bus2.id_dst      = '0;
        bus2.id_avail    = '0;
        bus2.id_src      = '0;
        bus2.id_src_used = '0;
        bus2.id_src_need = '0;

        rst = 1'b1;
        #1 rst = 1'b0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            runRow(tbl[i], $sformatf("row%0d", i));
        end

        // Asynchronous reset clears the counter without a clock edge.
        @(negedge clk);
        applyStimulus(bubble(0,0));
        #1 rst = 1'b0;
        #1 checkOutput("async clear stall_cnt", bus.stall_cnt, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Five load-use pairs build stall_cnt to 5.
        for (int i = 0; i < 5; i++) begin
            lw5  = mkVec(1,0,1,5,2, 0,0,0,0,0, 0,0,0,(i == 0) ? 0 : 3,0,i);
            runRow(lw5, $sformatf("lu%0d lw", i));
            use5 = mkVec(1,0,1,6,1, 5,0,1,1,1, 1,0,0,0,0,i);
            runRow(use5, $sformatf("lu%0d stall", i));
            use5 = mkVec(1,0,1,6,1, 5,0,1,1,1, 0,0,0,0,0,i+1);
            runRow(use5, $sformatf("lu%0d issue", i));
        end
        // Branch on r6 stalls with fwd_ex still pointing at WB; reset lands mid-stall.
        runRow(mkVec(1,0,0,0,1, 6,0,1,0,0, 1,0,0,3,0,5), "pre-reset");
        #1 rst = 1'b0;
        #1 checkAllZero("mid-stall reset");
        @(negedge clk);
        rst = 1'b1;

        // Deep instance: one writer stalls itself 15 of every 16 cycles.
        bus2.id_valid    = 1'b1;
        bus2.id_flush    = 1'b0;
        bus2.id_wr       = 1'b1;
        bus2.id_dst      = 5'd5;
        bus2.id_avail    = 4'd15;
        bus2.id_src      = {5'd0, 5'd5};
        bus2.id_src_used = 2'b01;
        bus2.id_src_need = {4'd0, 4'd0};
        #2 checkOutput("sat first issue stall", 16'(bus2.stall), 16'd0);
        repeat (16) @(negedge clk);
        #2;
        checkOutput("sat 16 cycles stall_cnt", bus2.stall_cnt, 16'd15);
        checkOutput("sat 16 cycles stall",     16'(bus2.stall), 16'd0);
        repeat (69904) @(negedge clk);
        #2;
        checkOutput("sat held stall_cnt", bus2.stall_cnt, 16'hFFFF);
        bus2.id_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-select unit for the in-order pipelined CPU.
- It tracks in-flight register writers in a shift-register scoreboard, one slot per post-ID stage.
- For each ID-stage instruction it generates the stall request, an ID-stage forward select (for branch/jr operands) and a registered EX-stage forward select.
- It replaces the hand-written per-operand stall equations and Forward chains with a block generalised over source count, pipeline depth and per-writer result latency.

Parameters:
- NSRC, 2, number of source operands checked per instruction.
- AW, 5, register-address width (register 0 is hard-wired zero).
- DEPTH, 3, number of tracked stages after ID (slot 1=EX, 2=MEM, 3=WB).
- SW, 2, stage-index width; must satisfy 2^SW > DEPTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (rst=0 resets).
- id_valid  in  1  ID holds a real instruction (not a bubble).
- id_flush  in  1  ID instruction is squashed this cycle (taken branch/jump); it is not issued.
- id_wr  in  1  ID instruction writes a register.
- id_dst  in  AW  destination register.
- id_avail  in  SW  stage at whose end the result exists (1=ALU, 2=load).
- id_src  in  NSRC*AW  source register addresses, source j at [j*AW +: AW].
- id_src_used  in  NSRC  source j is actually read.
- id_src_need  in  NSRC*SW  stage at which source j is consumed (0=ID, 1=EX).
- stall  out  1  hold PC/ID; insert a bubble into EX.
- fwd_id  out  NSRC*SW  slot currently holding the forwardable value for source j; 0 selects the regfile.
- fwd_ex  out  NSRC*SW  registered select for the EX-stage operand mux; 0 selects the latched ID value.
- stall_cnt  out  16  saturating count of stall cycles.

Behaviour:
- Scoreboard: slot[1..DEPTH], each slot holds {valid, dst, avail}.
- Issue condition: issue = id_valid & ~id_flush & ~stall.
- Every clock edge:
  - slot[1] <= issue & id_wr & (id_dst != 0) ? {1, id_dst, id_avail} : invalid.
  - slot[k+1] <= slot[k].
  - slot[DEPTH] retires.
- Match rule for source j (only when id_src_used[j] and src != 0):
  - Priority search from slot 1 (youngest) to DEPTH; the first valid slot s with dst == src wins.
  - Older matches are shadowed by the winner.
- Stall: stall = OR over j of (match at s, and s + need <= avail). This is purely combinational and has no registered latency.
  - ALU producer in EX, EX consumer: 1+1 > 1, no stall.
  - Load producer in EX, EX consumer: 2 <= 2, stall 1 cycle.
  - ALU producer in EX, ID consumer: 1 <= 1, stall 1 cycle.
  - Load producer in EX, ID consumer: stall 2 cycles.
- fwd_id[j] = s if a match exists and s > avail, else 0.
- fwd_ex register:
  - On a clock edge with issue: fwd_ex[j] <= (match, s+1 <= DEPTH, s+1 > avail) ? s+1 : 0.
  - s+1 > DEPTH means the producer has retired; the regfile writes on the falling edge, so 0 is correct.
  - On stall, flush or ~id_valid: fwd_ex <= 0 (bubble).
- stall_cnt increments on every cycle with stall=1 and saturates at 16'hFFFF.
- A writer to register 0 is never entered in the scoreboard; source 0 never matches.
- Simultaneous stall and id_flush: flush wins. The stall output still reflects the match, but nothing issues; the upstream PC logic gives the jump priority.
- Reset (rst=0, any time, mid-stall included):
  - All slots invalid.
  - fwd_ex = 0, stall_cnt = 0.
  - Hence stall = 0 and fwd_id = 0 while in reset.
- Release of rst is synchronised upstream; the first edge after release behaves as an empty pipeline.

Decomposition:
- Shared header constants in header.v: STG_ID=0, STG_EX=1, STG_MEM=2, STG_WB=3, AVAIL_ALU=1, AVAIL_LOAD=2.
- NEED_ID/NEED_EX encodings in the same header, consumed by InstrRegRead.
- Sub-module hazard_match: combinational priority search for one source over all slots. It outputs hit, slot index and avail, and is instantiated NSRC times via generate.

Test Plan:
- Back-to-back ALU: add r3 <- ..., then add r4 <- r3 (need=1) -> stall=0; next cycle fwd_ex[0]=2 (MEM).
- Load-use: lw r5 (avail=2), then add r6 <- r5 -> stall=1 for exactly 1 cycle; then fwd_ex[0]=3 (WB); stall_cnt=1.
- Branch after ALU: add r2, then beq r2,r7 (need=0) -> stall 1 cycle; then fwd_id[0]=2, fwd_id[1]=0.
- Shadowing: add r8 at slot 2, lw r8 at slot 1, consumer of r8 (need=1) -> stall=1 (the younger load wins); the older ALU result is not used.
- Register 0 and flush: writer to r0 then reader of r0 -> no stall, fwd=0; id_flush=1 with a writer in ID -> slot[1] invalid next cycle.
- Reset mid-operation: rst=0 during a load-use stall with stall_cnt=5 -> stall=0, fwd_ex=0, stall_cnt=0 immediately (asynchronous); count 16'hFFFF stalls -> the counter holds at 16'hFFFF.
